// File: rtl/pr_pkg.sv
// Shared types, Q8.24 constants and saturating fixed-point helpers for the
// memristive chaotic-oscillator random bit source.
package pr_pkg;

  localparam int W           = 32;
  localparam int FRAC        = 24;
  localparam int RAW_PER_VAR = 22;
  localparam int NUM_VARS    = 4;
  localparam int RAW_W       = RAW_PER_VAR * NUM_VARS;
  localparam int DEB_W       = RAW_W / 2;
  localparam int CNT_W       = 7;
  localparam int H_SHIFT     = 6;

  typedef logic signed [W-1:0] q_t;

  localparam q_t Q_MAX     = 32'sh7fff_ffff;
  localparam q_t Q_MIN     = 32'sh8000_0000;
  localparam q_t Q_ONE     = 32'sd16777216;
  localparam q_t Q_NEG_ONE = -32'sd16777216;

  // Coefficients are round-to-nearest of value * 2^24.
  localparam q_t C_0_3  = 32'sd5033165;
  localparam q_t C_0_5  = 32'sd8388608;
  localparam q_t C_0_6  = 32'sd10066330;
  localparam q_t C_0_7  = 32'sd11744051;
  localparam q_t C_1_1  = 32'sd18454938;
  localparam q_t C_1_2  = 32'sd20132659;
  localparam q_t C_1_5  = 32'sd25165824;
  localparam q_t C_2_0  = 32'sd33554432;
  localparam q_t C_2_9  = 32'sd48653926;
  localparam q_t C_4_75 = 32'sd79691776;

  localparam q_t H_SIXTH = 32'sd43691;

  localparam q_t X_INIT   = 32'sh0019_999A;
  localparam q_t PHI_INIT = 32'sd0;

  typedef enum logic [2:0] {IDLE, K1, K2, K3, K4, UPD, OUT} state_t;

  typedef struct packed {
    q_t x1;
    q_t x2;
    q_t x3;
    q_t phi;
  } pr_state_t;

  localparam pr_state_t STATE_INIT = '{x1: X_INIT, x2: X_INIT, x3: X_INIT, phi: PHI_INIT};

  function automatic q_t sat_add(q_t a, q_t b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? Q_MIN : Q_MAX;
    return q_t'(s);
  endfunction

  function automatic q_t sat_sub(q_t a, q_t b);
    logic signed [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? Q_MIN : Q_MAX;
    return q_t'(s);
  endfunction

  // Full-width product, arithmetic shift back to Q8.24, then wrap to 32 bits.
  function automatic q_t q_mul(q_t a, q_t b);
    logic signed [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    return q_t'(p >>> FRAC);
  endfunction

  function automatic q_t clamp1(q_t v);
    if (v > Q_ONE)     return Q_ONE;
    if (v < Q_NEG_ONE) return Q_NEG_ONE;
    return v;
  endfunction

endpackage

// File: rtl/pr_deriv.sv
// Combinational vector field of the memristive oscillator; each sum is built
// left to right with saturation at every step.
module pr_deriv
  import pr_pkg::*;
(
  input  pr_state_t s,
  output pr_state_t d
);

  q_t f1, f2, f3;
  q_t t1a, t1b, t2a, t3a, t3b;
  q_t phi_sq, gain, mem_term;

  always_comb begin
    f1 = clamp1(s.x1);
    f2 = clamp1(s.x2);
    f3 = clamp1(s.x3);

    t1a  = sat_sub(q_mul(C_1_5, f1), s.x1);
    t1b  = sat_sub(t1a, q_mul(C_2_9, f2));
    d.x1 = sat_add(t1b, q_mul(C_0_7, f3));

    t2a  = sat_sub(q_mul(C_2_0, f1), s.x2);
    d.x2 = sat_add(t2a, q_mul(C_1_2, f2));

    // Memristor coupling evaluated as (0.6 * (1 - 0.3*phi^2)) * x1.
    phi_sq   = q_mul(s.phi, s.phi);
    gain     = q_mul(C_0_6, sat_sub(Q_ONE, q_mul(C_0_3, phi_sq)));
    mem_term = q_mul(gain, s.x1);

    t3a  = sat_sub(q_mul(C_1_1, f3), s.x3);
    t3b  = sat_sub(t3a, q_mul(C_4_75, f1));
    d.x3 = sat_add(t3b, mem_term);

    d.phi = sat_sub(s.x3, q_mul(C_0_5, s.phi));
  end

endmodule

// File: rtl/pr.sv
// RK4 integrator of the oscillator sharing one derivative unit over K1..K4,
// followed by raw bit extraction and a von Neumann debiaser.
module pr
  import pr_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [RAW_W-1:0] raw_bits,
  output logic [DEB_W-1:0] debiased_bits,
  output logic [CNT_W-1:0] debiased_count,
  output logic [CNT_W-1:0] raw_count,
  output logic             bits_ready
);

  localparam int IDX_W = $clog2(DEB_W);
  localparam logic [CNT_W-1:0] RAW_COUNT = CNT_W'(RAW_W);

  state_t    state, state_nxt;
  pr_state_t s, k_prev, acc;
  pr_state_t deriv_in, deriv_out, acc_nxt, s_upd;

  logic [RAW_W-1:0] raw_now;
  logic [DEB_W-1:0] deb_bits;
  logic [CNT_W-1:0] deb_cnt;

  function automatic q_t ashr(q_t v, int sh);
    return v >>> sh;
  endfunction

  function automatic pr_state_t add_st(pr_state_t a, pr_state_t b);
    pr_state_t r;
    r.x1  = sat_add(a.x1,  b.x1);
    r.x2  = sat_add(a.x2,  b.x2);
    r.x3  = sat_add(a.x3,  b.x3);
    r.phi = sat_add(a.phi, b.phi);
    return r;
  endfunction

  function automatic pr_state_t add_scaled(pr_state_t a, pr_state_t k, int sh);
    pr_state_t r;
    r.x1  = sat_add(a.x1,  ashr(k.x1,  sh));
    r.x2  = sat_add(a.x2,  ashr(k.x2,  sh));
    r.x3  = sat_add(a.x3,  ashr(k.x3,  sh));
    r.phi = sat_add(a.phi, ashr(k.phi, sh));
    return r;
  endfunction

  function automatic pr_state_t mul_st(q_t c, pr_state_t a);
    pr_state_t r;
    r.x1  = q_mul(c, a.x1);
    r.x2  = q_mul(c, a.x2);
    r.x3  = q_mul(c, a.x3);
    r.phi = q_mul(c, a.phi);
    return r;
  endfunction

  pr_deriv u_deriv (
    .s (deriv_in),
    .d (deriv_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Once started, an iteration always runs to OUT; start is only looked at
  // in IDLE and OUT.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = K1;
      K1:      state_nxt = K2;
      K2:      state_nxt = K3;
      K3:      state_nxt = K4;
      K4:      state_nxt = UPD;
      UPD:     state_nxt = OUT;
      OUT:     state_nxt = start ? K1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage operand: K2/K3 probe at s + (h/2)k, K4 at s + h*k.
  always_comb begin
    deriv_in = s;
    acc_nxt  = acc;
    unique case (state)
      K1: acc_nxt = deriv_out;
      K2, K3: begin
        deriv_in = add_scaled(s, k_prev, H_SHIFT + 1);
        acc_nxt  = add_st(acc, add_st(deriv_out, deriv_out));
      end
      K4: begin
        deriv_in = add_scaled(s, k_prev, H_SHIFT);
        acc_nxt  = add_st(acc, deriv_out);
      end
      default: ;
    endcase
  end

  assign s_upd = add_st(s, mul_st(H_SIXTH, acc));

  assign raw_now = {s.phi[RAW_PER_VAR-1:0], s.x3[RAW_PER_VAR-1:0],
                    s.x2[RAW_PER_VAR-1:0],  s.x1[RAW_PER_VAR-1:0]};

  // Unequal pairs emit their lower bit, packed densely from bit 0.
  always_comb begin
    deb_bits = '0;
    deb_cnt  = '0;
    for (int i = 0; i < DEB_W; i++) begin
      if (raw_now[2*i] != raw_now[2*i+1]) begin
        deb_bits[deb_cnt[IDX_W-1:0]] = raw_now[2*i];
        deb_cnt = deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s              <= STATE_INIT;
      k_prev         <= '0;
      acc            <= '0;
      raw_bits       <= '0;
      debiased_bits  <= '0;
      debiased_count <= '0;
      raw_count      <= '0;
      bits_ready     <= 1'b0;
    end else begin
      bits_ready <= (state == OUT);
      if (state == K1 || state == K2 || state == K3 || state == K4) begin
        k_prev <= deriv_out;
        acc    <= acc_nxt;
      end
      if (state == UPD) s <= s_upd;
      if (state == OUT) begin
        raw_bits       <= raw_now;
        debiased_bits  <= deb_bits;
        debiased_count <= deb_cnt;
        raw_count      <= RAW_COUNT;
      end
    end
  end

endmodule

// File: tb/tb_pr.sv
// Bench for pr: control table, reset/restart sequences and a long randomized
// run, all checked against an integer/real reference model of the oscillator.
module tb_pr;

  localparam real SCALE = 16777216.0;
  localparam int ONE   = $rtoi(1.0  * SCALE + 0.5);
  localparam int INIT  = $rtoi(0.1  * SCALE + 0.5);
  localparam int C03   = $rtoi(0.3  * SCALE + 0.5);
  localparam int C05   = $rtoi(0.5  * SCALE + 0.5);
  localparam int C06   = $rtoi(0.6  * SCALE + 0.5);
  localparam int C07   = $rtoi(0.7  * SCALE + 0.5);
  localparam int C11   = $rtoi(1.1  * SCALE + 0.5);
  localparam int C12   = $rtoi(1.2  * SCALE + 0.5);
  localparam int C15   = $rtoi(1.5  * SCALE + 0.5);
  localparam int C20   = $rtoi(2.0  * SCALE + 0.5);
  localparam int C29   = $rtoi(2.9  * SCALE + 0.5);
  localparam int C475  = $rtoi(4.75 * SCALE + 0.5);
  localparam int H6    = $rtoi(SCALE / 384.0 + 0.5);
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct { int x1; int x2; int x3; int phi; } gst_t;
  typedef struct { logic rst; logic st; logic exp_ready; } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [87:0] raw_bits;
  logic [43:0] debiased_bits;
  logic [6:0]  debiased_count;
  logic [6:0]  raw_count;
  logic        bits_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int phase    = 0;
  int pulses   = 0;
  logic prev_ready = 1'b0;

  gst_t        gs;
  logic [87:0] exp_raw = '0;
  logic [43:0] exp_deb = '0;
  logic [6:0]  exp_dc = '0;
  logic [6:0]  exp_rc = '0;
  logic        exp_ready = 1'b0;
  logic [87:0] first_gold = '0;
  vec_t        vecs[28];

  pr dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .raw_bits       (raw_bits),
    .debiased_bits  (debiased_bits),
    .debiased_count (debiased_count),
    .raw_count      (raw_count),
    .bits_ready     (bits_ready)
  );

  always #5 clk = ~clk;

  function automatic int sat(longint v);
    if (v > MAXV) return int'(MAXV);
    if (v < MINV) return int'(MINV);
    return int'(v);
  endfunction

  function automatic int add(int a, int b);
    return sat(longint'(a) + longint'(b));
  endfunction

  function automatic int sub(int a, int b);
    return sat(longint'(a) - longint'(b));
  endfunction

  function automatic int mulq(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 24);
  endfunction

  function automatic int clampq(int v);
    if (v > ONE)  return ONE;
    if (v < -ONE) return -ONE;
    return v;
  endfunction

  function automatic gst_t deriv(gst_t s);
    gst_t d;
    int f1, f2, f3, g;
    f1 = clampq(s.x1);
    f2 = clampq(s.x2);
    f3 = clampq(s.x3);
    d.x1  = add(sub(sub(mulq(C15, f1), s.x1), mulq(C29, f2)), mulq(C07, f3));
    d.x2  = add(sub(mulq(C20, f1), s.x2), mulq(C12, f2));
    g     = mulq(mulq(C06, sub(ONE, mulq(C03, mulq(s.phi, s.phi)))), s.x1);
    d.x3  = add(sub(sub(mulq(C11, f3), s.x3), mulq(C475, f1)), g);
    d.phi = sub(s.x3, mulq(C05, s.phi));
    return d;
  endfunction

  function automatic gst_t axpy(gst_t s, gst_t k, int sh);
    gst_t r;
    r.x1  = add(s.x1,  k.x1  >>> sh);
    r.x2  = add(s.x2,  k.x2  >>> sh);
    r.x3  = add(s.x3,  k.x3  >>> sh);
    r.phi = add(s.phi, k.phi >>> sh);
    return r;
  endfunction

  function automatic int combine(int s, int a, int b, int c, int d);
    int acc;
    acc = add(add(add(a, add(b, b)), add(c, c)), d);
    return add(s, mulq(H6, acc));
  endfunction

  function automatic gst_t rk4(gst_t s);
    gst_t k1, k2, k3, k4, r;
    k1 = deriv(s);
    k2 = deriv(axpy(s, k1, 7));
    k3 = deriv(axpy(s, k2, 7));
    k4 = deriv(axpy(s, k3, 6));
    r.x1  = combine(s.x1,  k1.x1,  k2.x1,  k3.x1,  k4.x1);
    r.x2  = combine(s.x2,  k1.x2,  k2.x2,  k3.x2,  k4.x2);
    r.x3  = combine(s.x3,  k1.x3,  k2.x3,  k3.x3,  k4.x3);
    r.phi = combine(s.phi, k1.phi, k2.phi, k3.phi, k4.phi);
    return r;
  endfunction

  function automatic logic [87:0] pack_raw(gst_t s);
    return {s.phi[21:0], s.x3[21:0], s.x2[21:0], s.x1[21:0]};
  endfunction

  function automatic void debias(input logic [87:0] raw, output logic [43:0] bits,
                                 output logic [6:0] cnt);
    bit q[$];
    for (int i = 0; i < 44; i++)
      if (raw[2*i] != raw[2*i+1]) q.push_back(raw[2*i]);
    bits = '0;
    foreach (q[j]) bits[j] = q[j];
    cnt = 7'(q.size());
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Drives one cycle of inputs at a negedge, returns at the next negedge with
  // the model advanced over the posedge in between.
  task automatic applyStimulus(input logic r, input logic s);
    reset = r;
    start = s;
    @(negedge clk);
    exp_ready = 1'b0;
    if (r) begin
      phase   = 0;
      gs      = '{INIT, INIT, INIT, 0};
      exp_raw = '0;
      exp_deb = '0;
      exp_dc  = '0;
      exp_rc  = '0;
    end else if (phase == 0) begin
      phase = s ? 1 : 0;
    end else if (phase == 6) begin
      exp_ready = 1'b1;
      gs        = rk4(gs);
      exp_raw   = pack_raw(gs);
      debias(exp_raw, exp_deb, exp_dc);
      exp_rc    = 7'd88;
      phase     = s ? 1 : 0;
    end else begin
      phase++;
    end
  endtask

  task automatic checkOutput();
    chk("bits_ready",     128'(bits_ready),     128'(exp_ready));
    chk("raw_bits",       128'(raw_bits),       128'(exp_raw));
    chk("debiased_bits",  128'(debiased_bits),  128'(exp_deb));
    chk("debiased_count", 128'(debiased_count), 128'(exp_dc));
    chk("raw_count",      128'(raw_count),      128'(exp_rc));
    if (bits_ready) begin
      pulses++;
      chk("ready_width", 128'(prev_ready), 128'(0));
      chk("deb_count_max", 128'(debiased_count <= 7'd44), 128'(1));
    end
    prev_ready = bits_ready;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    gs = '{INIT, INIT, INIT, 0};

    // Reset 3 cycles, idle, start for 14 cycles, then drop start two cycles
    // into the third iteration; pulses land on records 11, 17 and 23.
    for (int i = 0; i < 28; i++) begin
      if (i < 3)       vecs[i] = '{1'b1, 1'b0, 1'b0};
      else if (i < 5)  vecs[i] = '{1'b0, 1'b0, 1'b0};
      else if (i < 19) vecs[i] = '{1'b0, 1'b1, 1'b0};
      else             vecs[i] = '{1'b0, 1'b0, 1'b0};
    end
    vecs[11].exp_ready = 1'b1;
    vecs[17].exp_ready = 1'b1;
    vecs[23].exp_ready = 1'b1;

    @(negedge clk);
    $display("[TB] control table");
    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].st);
      chk("tbl_ready", 128'(bits_ready), 128'(vecs[i].exp_ready));
      checkOutput();
      if (i == 11) first_gold = exp_raw;
    end

    $display("[TB] reset during K3 of iteration 5");
    applyStimulus(1'b1, 1'b0); checkOutput();
    applyStimulus(1'b1, 1'b0); checkOutput();
    pulses = 0;
    for (int j = 0; j < 27; j++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput();
    end
    chk("pulses_before_reset", 128'(pulses), 128'(4));
    applyStimulus(1'b1, 1'b1);
    checkOutput();
    pulses = 0;
    for (int j = 0; j < 7; j++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput();
      if (j == 6) chk("restart_raw", 128'(raw_bits), 128'(first_gold));
    end
    chk("pulses_after_restart", 128'(pulses), 128'(1));

    $display("[TB] 1000 continuous iterations");
    applyStimulus(1'b1, 1'b0); checkOutput();
    applyStimulus(1'b1, 1'b0); checkOutput();
    pulses = 0;
    for (int j = 0; j < 6006; j++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput();
    end
    chk("pulses_1000", 128'(pulses), 128'(1000));

    $display("[TB] randomized start/reset");
    for (int j = 0; j < 3000; j++) begin
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) != 0));
      checkOutput();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
